// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core: data width, LSU state encoding,
// memory access width codes and small helpers for byte lanes and alignment.
package npc_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    localparam logic [1:0] LSU_B = 2'd0;
    localparam logic [1:0] LSU_H = 2'd1;
    localparam logic [1:0] LSU_W = 2'd2;
    localparam logic [1:0] LSU_D = 2'd3;

    // Byte enables for an access; lanes beyond the doubleword fall off the top.
    function automatic logic [7:0] lsu_wstrb(input logic [2:0] addr_lo, input logic [1:0] width);
        logic [7:0] base;
        case (width)
            LSU_B:   base = 8'h01;
            LSU_H:   base = 8'h03;
            LSU_W:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << addr_lo;
    endfunction

    function automatic logic lsu_is_misaligned(input logic [2:0] addr_lo, input logic [1:0] width);
        logic bad;
        case (width)
            LSU_H:   bad = addr_lo[0];
            LSU_W:   bad = |addr_lo[1:0];
            LSU_D:   bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the returned doubleword down to the
// accessed byte, keeps 8/16/32/64 bits and sign- or zero-extends them.
module lsu_load_align
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr_lo,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic            sign_en;

    assign shifted = rdata >> {addr_lo, 3'b000};
    assign sign_en = ~func3[2];

    always_comb begin
        data = shifted;
        case (func3[1:0])
            LSU_B:   data = {{56{sign_en & shifted[7]}},  shifted[7:0]};
            LSU_H:   data = {{48{sign_en & shifted[15]}}, shifted[15:0]};
            LSU_W:   data = {{32{sign_en & shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Memory stage of the NPC core: single-entry holding register, valid/ready data
// memory port and one writeback record per instruction. Optional alignment
// checking is enabled with LSU_MISALIGN_CHK_EN.
module lsu_stage
    import npc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    input  logic [XLEN-1:0] exu_rd,
    input  logic [4:0]      exu_rd_addr,
    input  logic            exu_rd_w,
    input  logic            exu_ld,
    input  logic            exu_st,
    input  logic [2:0]      exu_func3,
    input  logic [XLEN-1:0] exu_st_data,
    output logic            pipe4_allowin,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic            dmem_req_wen,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [7:0]      dmem_req_wstrb,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_rd,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_rd_w
`ifdef LSU_MISALIGN_CHK_EN
    ,
    output logic            misalign
`endif
);

    lsu_state_t      state;
    logic [2:0]      addr_lo_q;
    logic [2:0]      func3_q;
    logic [4:0]      rd_addr_q;
    logic            rd_w_q;
    logic            is_mem;
    logic            access_misaligned;
    logic [XLEN-1:0] load_data;

    assign pipe4_allowin = (state == IDLE);
    assign is_mem        = exu_ld | exu_st;

`ifdef LSU_MISALIGN_CHK_EN
    assign access_misaligned = lsu_is_misaligned(exu_rd[2:0], exu_func3[1:0]);
`else
    assign access_misaligned = 1'b0;
`endif

    lsu_load_align u_load_align (
        .rdata   (dmem_resp_rdata),
        .addr_lo (addr_lo_q),
        .func3   (func3_q),
        .data    (load_data)
    );

    // Request outputs are loaded on acceptance and held untouched until the
    // handshake, so the memory side sees a stable request however long it stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr_lo_q      <= 3'd0;
            func3_q        <= 3'd0;
            rd_addr_q      <= 5'd0;
            rd_w_q         <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wen   <= 1'b0;
            dmem_req_wdata <= '0;
            dmem_req_wstrb <= 8'h00;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_rd_addr     <= 5'd0;
            wb_rd_w        <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
            misalign       <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            wb_rd_w  <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
            misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (exu_valid) begin
                        addr_lo_q <= exu_rd[2:0];
                        func3_q   <= exu_func3;
                        rd_addr_q <= exu_rd_addr;
                        rd_w_q    <= exu_rd_w;
                        if (!is_mem) begin
                            wb_valid   <= 1'b1;
                            wb_rd      <= exu_rd;
                            wb_rd_addr <= exu_rd_addr;
                            wb_rd_w    <= exu_rd_w;
                        end else if (access_misaligned) begin
                            wb_valid   <= 1'b1;
                            wb_rd      <= '0;
                            wb_rd_addr <= exu_rd_addr;
                            wb_rd_w    <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
                            misalign   <= 1'b1;
`endif
                        end else begin
                            state          <= REQ;
                            dmem_req_valid <= 1'b1;
                            dmem_req_addr  <= {exu_rd[XLEN-1:3], 3'b000};
                            dmem_req_wen   <= exu_st;
                            dmem_req_wdata <= exu_st ? (exu_st_data << {exu_rd[2:0], 3'b000}) : '0;
                            dmem_req_wstrb <= exu_st ? lsu_wstrb(exu_rd[2:0], exu_func3[1:0]) : 8'h00;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        if (dmem_req_wen) begin
                            state      <= IDLE;
                            wb_valid   <= 1'b1;
                            wb_rd      <= '0;
                            wb_rd_addr <= rd_addr_q;
                            wb_rd_w    <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_resp_valid) begin
                        state      <= IDLE;
                        wb_valid   <= 1'b1;
                        wb_rd      <= load_data;
                        wb_rd_addr <= rd_addr_q;
                        wb_rd_w    <= rd_w_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed testbench for lsu_stage with hand-computed expectations; the
// misalignment steps are built only when LSU_MISALIGN_CHK_EN is defined.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid;
    logic [63:0] exu_rd;
    logic [4:0]  exu_rd_addr;
    logic        exu_rd_w;
    logic        exu_ld;
    logic        exu_st;
    logic [2:0]  exu_func3;
    logic [63:0] exu_st_data;
    logic        pipe4_allowin;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_req_addr;
    logic        dmem_req_wen;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_rdata;
    logic        wb_valid;
    logic [63:0] wb_rd;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_w;
`ifdef LSU_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk             (clk),
        .rst             (rst),
        .exu_valid       (exu_valid),
        .exu_rd          (exu_rd),
        .exu_rd_addr     (exu_rd_addr),
        .exu_rd_w        (exu_rd_w),
        .exu_ld          (exu_ld),
        .exu_st          (exu_st),
        .exu_func3       (exu_func3),
        .exu_st_data     (exu_st_data),
        .pipe4_allowin   (pipe4_allowin),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wen    (dmem_req_wen),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_rd_addr      (wb_rd_addr),
        .wb_rd_w         (wb_rd_w)
`ifdef LSU_MISALIGN_CHK_EN
        ,
        .misalign        (misalign)
`endif
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] rd, input logic [4:0] ra,
                                 input logic rw, input logic ld, input logic st,
                                 input logic [2:0] f3, input logic [63:0] sd);
        exu_valid   = v;
        exu_rd      = rd;
        exu_rd_addr = ra;
        exu_rd_w    = rw;
        exu_ld      = ld;
        exu_st      = st;
        exu_func3   = f3;
        exu_st_data = sd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doLoad(input string tag, input logic [63:0] a, input logic [2:0] f3,
                          input logic [63:0] rdata, input logic [63:0] expected);
        applyStimulus(1'b1, a, 5'd9, 1'b1, 1'b1, 1'b0, f3, 64'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        checkOutput({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd1);
        checkOutput({tag, "_req_addr"}, dmem_req_addr, {a[63:3], 3'b000});
        checkOutput({tag, "_req_wen"}, 64'(dmem_req_wen), 64'd0);
        checkOutput({tag, "_req_wstrb"}, 64'(dmem_req_wstrb), 64'd0);
        checkOutput({tag, "_allowin"}, 64'(pipe4_allowin), 64'd0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        checkOutput({tag, "_req_dropped"}, 64'(dmem_req_valid), 64'd0);
        checkOutput({tag, "_no_early_wb"}, 64'(wb_valid), 64'd0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        tick();
        dmem_resp_valid = 1'b0;
        checkOutput({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
        checkOutput({tag, "_wb_rd"}, wb_rd, expected);
        checkOutput({tag, "_wb_rd_w"}, 64'(wb_rd_w), 64'd1);
        checkOutput({tag, "_wb_rd_addr"}, 64'(wb_rd_addr), 64'd9);
        tick();
        checkOutput({tag, "_wb_pulse"}, 64'(wb_valid), 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 64'd0;
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        tick();
        tick();
        checkOutput("rst_allowin", 64'(pipe4_allowin), 64'd1);
        checkOutput("rst_req_valid", 64'(dmem_req_valid), 64'd0);
        checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("rst_wb_rd", wb_rd, 64'd0);
        checkOutput("rst_wstrb", 64'(dmem_req_wstrb), 64'd0);
        rst = 1'b0;

        $display("[TB] non-memory instruction");
        applyStimulus(1'b1, 64'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 64'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        checkOutput("add_wb_valid", 64'(wb_valid), 64'd1);
        checkOutput("add_wb_rd", wb_rd, 64'h1234);
        checkOutput("add_wb_rd_addr", 64'(wb_rd_addr), 64'd5);
        checkOutput("add_wb_rd_w", 64'(wb_rd_w), 64'd1);
        checkOutput("add_allowin", 64'(pipe4_allowin), 64'd1);
        tick();
        checkOutput("add_wb_pulse", 64'(wb_valid), 64'd0);

        $display("[TB] back-to-back non-memory");
        applyStimulus(1'b1, 64'h11, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0, 64'd0);
        tick();
        checkOutput("b2b0_wb_rd", wb_rd, 64'h11);
        applyStimulus(1'b1, 64'h22, 5'd2, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        checkOutput("b2b1_wb_valid", 64'(wb_valid), 64'd1);
        checkOutput("b2b1_wb_rd", wb_rd, 64'h22);
        checkOutput("b2b1_wb_rd_w", 64'(wb_rd_w), 64'd0);
        tick();

        $display("[TB] response outside WAIT");
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'hDEAD;
        tick();
        dmem_resp_valid = 1'b0;
        checkOutput("idle_resp_ignored", 64'(wb_valid), 64'd0);

        $display("[TB] loads");
        doLoad("lb", 64'h8000_0003, 3'b000, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        doLoad("lbu", 64'h8000_0003, 3'b100, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080);
        doLoad("lw", 64'h8000_0104, 3'b010, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        doLoad("lhu", 64'h8000_0002, 3'b101, 64'h0000_0000_ABCD_0000, 64'h0000_0000_0000_ABCD);
        doLoad("ld", 64'h8000_0008, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        $display("[TB] store with stalled ready");
        applyStimulus(1'b1, 64'h8000_0006, 5'd3, 1'b1, 1'b0, 1'b1, 3'b001, 64'hABCD);
        tick();
        applyStimulus(1'b1, 64'h5555, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("sh_req_valid", 64'(dmem_req_valid), 64'd1);
            checkOutput("sh_req_addr", dmem_req_addr, 64'h8000_0000);
            checkOutput("sh_wstrb", 64'(dmem_req_wstrb), 64'hC0);
            checkOutput("sh_wdata", dmem_req_wdata, 64'hABCD_0000_0000_0000);
            checkOutput("sh_wen", 64'(dmem_req_wen), 64'd1);
            checkOutput("sh_allowin", 64'(pipe4_allowin), 64'd0);
            checkOutput("sh_no_wb", 64'(wb_valid), 64'd0);
            tick();
        end
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        checkOutput("sh_wb_valid", 64'(wb_valid), 64'd1);
        checkOutput("sh_wb_rd_w", 64'(wb_rd_w), 64'd0);
        checkOutput("sh_wb_rd", wb_rd, 64'd0);
        checkOutput("sh_req_dropped", 64'(dmem_req_valid), 64'd0);
        checkOutput("sh_allowin_back", 64'(pipe4_allowin), 64'd1);
        tick();
        checkOutput("sh_stalled_add_not_taken", 64'(wb_valid), 64'd0);

        $display("[TB] word store at lane 4");
        applyStimulus(1'b1, 64'h8000_0014, 5'd6, 1'b0, 1'b0, 1'b1, 3'b010, 64'h1122_3344);
        tick();
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        checkOutput("sw_req_addr", dmem_req_addr, 64'h8000_0010);
        checkOutput("sw_wstrb", 64'(dmem_req_wstrb), 64'hF0);
        checkOutput("sw_wdata", dmem_req_wdata, 64'h1122_3344_0000_0000);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        checkOutput("sw_wb_valid", 64'(wb_valid), 64'd1);
        tick();

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 64'h8000_0020, 5'd7, 1'b1, 1'b1, 1'b0, 3'b011, 64'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstw_req_valid", 64'(dmem_req_valid), 64'd0);
        checkOutput("rstw_allowin", 64'(pipe4_allowin), 64'd1);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'hFEED_FACE_CAFE_BEEF;
        tick();
        dmem_resp_valid = 1'b0;
        checkOutput("rstw_stale_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("rstw_wb_rd", wb_rd, 64'd0);
        checkOutput("rstw_wb_rd_w", 64'(wb_rd_w), 64'd0);
        checkOutput("rstw_wb_rd_addr", 64'(wb_rd_addr), 64'd0);
        checkOutput("rstw_req_addr", dmem_req_addr, 64'd0);
        checkOutput("rstw_wstrb", 64'(dmem_req_wstrb), 64'd0);

`ifdef LSU_MISALIGN_CHK_EN
        $display("[TB] misaligned word load");
        checkOutput("mis_reset", 64'(misalign), 64'd0);
        applyStimulus(1'b1, 64'h8000_0002, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 64'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        checkOutput("mis_no_req", 64'(dmem_req_valid), 64'd0);
        checkOutput("mis_flag", 64'(misalign), 64'd1);
        checkOutput("mis_wb_valid", 64'(wb_valid), 64'd1);
        checkOutput("mis_wb_rd_w", 64'(wb_rd_w), 64'd0);
        checkOutput("mis_allowin", 64'(pipe4_allowin), 64'd1);
        tick();
        checkOutput("mis_pulse", 64'(misalign), 64'd0);
        checkOutput("mis_still_no_req", 64'(dmem_req_valid), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
